// File: rtl/snes_pkg.sv
// Shared definitions for the S-CPU math unit: register offsets and the sequencer state.
package snes_pkg;

    // Write offsets from $4200
    localparam logic [3:0] MATH_WRMPYA = 4'd2;
    localparam logic [3:0] MATH_WRMPYB = 4'd3;
    localparam logic [3:0] MATH_WRDIVL = 4'd4;
    localparam logic [3:0] MATH_WRDIVH = 4'd5;
    localparam logic [3:0] MATH_WRDIVB = 4'd6;
    // Read offsets from $4210
    localparam logic [3:0] MATH_RDDIVL = 4'd4;
    localparam logic [3:0] MATH_RDDIVH = 4'd5;
    localparam logic [3:0] MATH_RDMPYL = 4'd6;
    localparam logic [3:0] MATH_RDMPYH = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } math_state_t;

endpackage

// File: rtl/snes_math_step.sv
// One combinational step of the shift-add multiply or restoring divide.
// Step k of a multiply adds A<<k when B[k] is set; step k of a divide tries to subtract D<<k.
module snes_math_step (
    input  logic        is_div_i,
    input  logic [3:0]  k_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    input  logic [7:0]  d_i,
    input  logic [15:0] rdmpy_i,
    input  logic [15:0] rddiv_i,
    output logic [15:0] rdmpy_o,
    output logic [15:0] rddiv_o
);

    logic [15:0] addend;
    logic [23:0] dshift;
    logic        q;

    always_comb begin
        addend  = {8'h00, a_i} << k_i;
        dshift  = {16'h0000, d_i} << k_i;
        // 24-bit compare so a large divisor shift never wraps into a false "fits"
        q       = ({8'h00, rdmpy_i} >= dshift);
        rdmpy_o = rdmpy_i;
        rddiv_o = rddiv_i;
        if (is_div_i) begin
            rddiv_o = {rddiv_i[14:0], q};
            if (q) rdmpy_o = rdmpy_i - dshift[15:0];
        end else if (b_i[k_i[2:0]]) begin
            rdmpy_o = rdmpy_i + addend;
        end
    end

endmodule

// File: rtl/snes_cpu_math.sv
// S-CPU 8x8 multiply / 16/8 divide unit with memory-mapped operand and result registers.
// Define SNES_MATH_INSTANT_EN to produce final results on the start write (BUSY stays low).
module snes_cpu_math
    import snes_pkg::*;
#(
    parameter int MUL_STEPS = 8,
    parameter int DIV_STEPS = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       WR,
    input  logic [3:0] RD_ADDR,
    input  logic [3:0] WR_ADDR,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       BUSY
);

    localparam logic [3:0] MUL_LAST  = 4'(MUL_STEPS - 1);
    localparam logic [3:0] DIV_FIRST = 4'(DIV_STEPS - 1);

    math_state_t state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [7:0]  wrmpya_q, wrmpya_d;
    logic [7:0]  wrdivl_q, wrdivl_d;
    logic [7:0]  wrdivh_q, wrdivh_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  d_q, d_d;
    logic [15:0] rdmpy_q, rdmpy_d;
    logic [15:0] rddiv_q, rddiv_d;
    logic [15:0] step_mpy, step_div;

    snes_math_step u_step (
        .is_div_i (state_q == DIV),
        .k_i      (k_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .d_i      (d_q),
        .rdmpy_i  (rdmpy_q),
        .rddiv_i  (rddiv_q),
        .rdmpy_o  (step_mpy),
        .rddiv_o  (step_div)
    );

`ifdef SNES_MATH_INSTANT_EN
    // Fully unrolled chains of the same step, fed straight from the start write.
    logic [MUL_STEPS:0][15:0] mchain;
    logic [MUL_STEPS-1:0][15:0] mchain_div;
    logic [DIV_STEPS:0][15:0] dchain_rem;
    logic [DIV_STEPS:0][15:0] dchain_quo;

    assign mchain[0]     = 16'h0000;
    assign dchain_rem[0] = {wrdivh_q, wrdivl_q};
    assign dchain_quo[0] = 16'h0000;

    for (genvar gi = 0; gi < MUL_STEPS; gi++) begin : g_mul
        snes_math_step u_mstep (
            .is_div_i (1'b0),
            .k_i      (4'(gi)),
            .a_i      (wrmpya_q),
            .b_i      (DI),
            .d_i      (8'h00),
            .rdmpy_i  (mchain[gi]),
            .rddiv_i  (16'h0000),
            .rdmpy_o  (mchain[gi+1]),
            .rddiv_o  (mchain_div[gi])
        );
    end

    for (genvar gi = 0; gi < DIV_STEPS; gi++) begin : g_div
        snes_math_step u_dstep (
            .is_div_i (1'b1),
            .k_i      (4'(DIV_STEPS - 1 - gi)),
            .a_i      (8'h00),
            .b_i      (8'h00),
            .d_i      (DI),
            .rdmpy_i  (dchain_rem[gi]),
            .rddiv_i  (dchain_quo[gi]),
            .rdmpy_o  (dchain_rem[gi+1]),
            .rddiv_o  (dchain_quo[gi+1])
        );
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            k_q      <= 4'd0;
            wrmpya_q <= 8'hFF;
            wrdivl_q <= 8'h00;
            wrdivh_q <= 8'h00;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            d_q      <= 8'h00;
            rdmpy_q  <= 16'h0000;
            rddiv_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            wrmpya_q <= wrmpya_d;
            wrdivl_q <= wrdivl_d;
            wrdivh_q <= wrdivh_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            rdmpy_q  <= rdmpy_d;
            rddiv_q  <= rddiv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wrmpya_d = wrmpya_q;
        wrdivl_d = wrdivl_q;
        wrdivh_d = wrdivh_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        rdmpy_d  = rdmpy_q;
        rddiv_d  = rddiv_q;

        if (EN) begin
            unique case (state_q)
                MUL: begin
                    rdmpy_d = step_mpy;
                    if (k_q == MUL_LAST) state_d = IDLE;
                    else                 k_d = k_q + 4'd1;
                end
                DIV: begin
                    rdmpy_d = step_mpy;
                    rddiv_d = step_div;
                    if (k_q == 4'd0) state_d = IDLE;
                    else             k_d = k_q - 4'd1;
                end
                default: ;
            endcase

            // Start writes come last so they override an in-flight step
            if (WR) begin
                unique case (WR_ADDR)
                    MATH_WRMPYA: wrmpya_d = DI;
                    MATH_WRDIVL: wrdivl_d = DI;
                    MATH_WRDIVH: wrdivh_d = DI;
                    MATH_WRMPYB: begin
                        a_d     = wrmpya_q;
                        b_d     = DI;
                        rddiv_d = {DI, wrmpya_q};
                        k_d     = 4'd0;
`ifdef SNES_MATH_INSTANT_EN
                        rdmpy_d = mchain[MUL_STEPS];
                        state_d = IDLE;
`else
                        rdmpy_d = 16'h0000;
                        state_d = MUL;
`endif
                    end
                    MATH_WRDIVB: begin
                        d_d     = DI;
                        k_d     = DIV_FIRST;
`ifdef SNES_MATH_INSTANT_EN
                        rdmpy_d = dchain_rem[DIV_STEPS];
                        rddiv_d = dchain_quo[DIV_STEPS];
                        state_d = IDLE;
`else
                        rdmpy_d = {wrdivh_q, wrdivl_q};
                        rddiv_d = 16'h0000;
                        state_d = DIV;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        DO = 8'h00;
        unique case (RD_ADDR)
            MATH_RDDIVL: DO = rddiv_q[7:0];
            MATH_RDDIVH: DO = rddiv_q[15:8];
            MATH_RDMPYL: DO = rdmpy_q[7:0];
            MATH_RDMPYH: DO = rdmpy_q[15:8];
            default:     DO = 8'h00;
        endcase
    end

    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_snes_cpu_math.sv
// Self-checking bench for snes_cpu_math: vector table, directed corner sequences, random ops.
module tb_snes_cpu_math;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       EN = 1'b0;
    logic       WR = 1'b0;
    logic [3:0] RD_ADDR = 4'd0;
    logic [3:0] WR_ADDR = 4'd0;
    logic [7:0] DI = 8'h00;
    logic [7:0] DO;
    logic       BUSY;

    int tests = 0;
    int fails = 0;

    snes_cpu_math dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .EN      (EN),
        .WR      (WR),
        .RD_ADDR (RD_ADDR),
        .WR_ADDR (WR_ADDR),
        .DI      (DI),
        .DO      (DO),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_div;
        logic [15:0] op1;
        logic [7:0]  op2;
        logic [15:0] exp_mpy;
        logic [15:0] exp_div;
    } vec_t;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        @(negedge CLK);
        EN = 1'b1; WR = 1'b1; WR_ADDR = addr; DI = data;
        @(negedge CLK);
        WR = 1'b0;
    endtask

    task automatic cycles(input int n);
        EN = 1'b1; WR = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic rd16(input logic [3:0] lo, output logic [15:0] val);
        RD_ADDR = lo;
        #1 val[7:0] = DO;
        RD_ADDR = lo + 4'd1;
        #1 val[15:8] = DO;
    endtask

    task automatic start_op(input bit is_div, input logic [15:0] op1, input logic [7:0] op2);
        if (is_div) begin
            wr(4'd4, op1[7:0]);
            wr(4'd5, op1[15:8]);
            wr(4'd6, op2);
        end else begin
            wr(4'd2, op1[7:0]);
            wr(4'd3, op2);
        end
    endtask

    // Expected {RDDIV, RDMPY} after n enabled steps, from plain arithmetic
    function automatic logic [31:0] model(input bit is_div, input logic [15:0] op1,
                                          input logic [7:0] op2, input int n);
        int unsigned a, b, dv, dd, sh, qp, r;
        logic [15:0] mpy, div;
        if (!is_div) begin
            a   = op1[7:0];
            b   = op2 & ((1 << n) - 1);
            mpy = 16'(a * b);
            div = {op2, op1[7:0]};
        end else if (op2 == 8'h00) begin
            mpy = op1;
            div = 16'((1 << n) - 1);
        end else begin
            dv  = op1;
            dd  = op2;
            sh  = dd << (16 - n);
            qp  = dv / sh;
            r   = dv - qp * sh;
            mpy = 16'(r);
            div = 16'(qp);
        end
        return {div, mpy};
    endfunction

    vec_t vecs[8];
    logic [15:0] rm, rq, rm2;
    logic [31:0] m;

    initial begin
        vecs[0] = '{1'b0, 16'h0012, 8'h34, 16'h03A8, 16'h3412};
        vecs[1] = '{1'b0, 16'h00FF, 8'hFF, 16'hFE01, 16'hFFFF};
        vecs[2] = '{1'b0, 16'h0000, 8'hFF, 16'h0000, 16'hFF00};
        vecs[3] = '{1'b0, 16'h0080, 8'h02, 16'h0100, 16'h0280};
        vecs[4] = '{1'b1, 16'h1234, 8'h56, 16'h0010, 16'h0036};
        vecs[5] = '{1'b1, 16'hABCD, 8'h00, 16'hABCD, 16'hFFFF};
        vecs[6] = '{1'b1, 16'h0005, 8'h07, 16'h0005, 16'h0000};
        vecs[7] = '{1'b1, 16'hFFFF, 8'h01, 16'h0000, 16'hFFFF};

        // Reset state
        #12;
        check("reset_busy", {15'd0, BUSY}, 16'h0000);
        rd16(4'd6, rm); check("reset_rdmpy", rm, 16'h0000);
        rd16(4'd4, rq); check("reset_rddiv", rq, 16'h0000);
        @(negedge CLK); RST_N = 1'b1;

        // WRMPYA resets to FF
        wr(4'd3, 8'h02);
        cycles(8);
        rd16(4'd6, rm); check("reset_wrmpya_mpy", rm, 16'h01FE);
        rd16(4'd4, rq); check("reset_wrmpya_div", rq, 16'h02FF);

        // Vector table
        foreach (vecs[i]) begin
            start_op(vecs[i].is_div, vecs[i].op1, vecs[i].op2);
            cycles(vecs[i].is_div ? 15 : 7);
            check($sformatf("vec%0d_busy_hi", i), {15'd0, BUSY}, 16'h0001);
            cycles(1);
            check($sformatf("vec%0d_busy_lo", i), {15'd0, BUSY}, 16'h0000);
            rd16(4'd6, rm); check($sformatf("vec%0d_rdmpy", i), rm, vecs[i].exp_mpy);
            rd16(4'd4, rq); check($sformatf("vec%0d_rddiv", i), rq, vecs[i].exp_div);
        end

        // Partial multiply after 4 steps
        start_op(1'b0, 16'h00FF, 8'hFF);
        cycles(4);
        rd16(4'd6, rm); check("partial_ff_ff", rm, 16'h0EF1);
        cycles(4);

        // Divide abandoned by a multiply start
        wr(4'd2, 8'h03);
        start_op(1'b1, 16'h1234, 8'h56);
        cycles(5);
        wr(4'd3, 8'h02);
        check("abandon_busy", {15'd0, BUSY}, 16'h0001);
        cycles(8);
        rd16(4'd6, rm); check("abandon_rdmpy", rm, 16'h0006);
        rd16(4'd4, rq); check("abandon_rddiv", rq, 16'h0203);
        check("abandon_idle", {15'd0, BUSY}, 16'h0000);

        // Operand writes during a multiply do not disturb it
        start_op(1'b0, 16'h0012, 8'h34);
        cycles(2);
        wr(4'd2, 8'h77);
        wr(4'd4, 8'h99);
        cycles(4);
        rd16(4'd6, rm); check("plain_wr_rdmpy", rm, 16'h03A8);

        // EN low freezes a running multiply
        start_op(1'b0, 16'h0012, 8'h34);
        cycles(3);
        rd16(4'd6, rm); check("freeze_before", rm, 16'h0048);
        EN = 1'b0;
        repeat (10) @(negedge CLK);
        rd16(4'd6, rm2); check("freeze_after", rm2, 16'h0048);
        check("freeze_busy", {15'd0, BUSY}, 16'h0001);
        cycles(5);
        rd16(4'd6, rm); check("freeze_final", rm, 16'h03A8);

        // Async reset mid-multiply
        start_op(1'b0, 16'h00FF, 8'hFF);
        cycles(3);
        #2 RST_N = 1'b0;
        #1;
        check("arst_busy", {15'd0, BUSY}, 16'h0000);
        rd16(4'd6, rm); check("arst_rdmpy", rm, 16'h0000);
        @(negedge CLK); RST_N = 1'b1;
        cycles(2);
        rd16(4'd6, rm); check("arst_stays", rm, 16'h0000);

        // Randomized ops with random early reads
        for (int t = 0; t < 40; t++) begin
            bit          isd;
            logic [15:0] o1;
            logic [7:0]  o2;
            int          n, full;
            isd  = 1'($urandom_range(0, 1));
            o1   = 16'($urandom);
            if (!isd) o1[15:8] = 8'h00;
            o2   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            full = isd ? 16 : 8;
            n    = $urandom_range(1, full);
            start_op(isd, o1, o2);
            cycles(n);
            m = model(isd, o1, o2, n);
            rd16(4'd6, rm); check($sformatf("rnd%0d_rdmpy_n%0d", t, n), rm, m[15:0]);
            rd16(4'd4, rq); check($sformatf("rnd%0d_rddiv_n%0d", t, n), rq, m[31:16]);
            if (n < full) cycles(full - n);
            m = model(isd, o1, o2, full);
            rd16(4'd6, rm); check($sformatf("rnd%0d_rdmpy_final", t), rm, m[15:0]);
            rd16(4'd4, rq); check($sformatf("rnd%0d_rddiv_final", t), rq, m[31:16]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
